rr_mux_arb: RTL and testbench

RR_MUX_ARB -- requirements
Module: rr_mux_arb

---
 rtl/mux_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 57 +++++
 rtl/rr_mux_arb.sv | 97 +++++++++
 tb/tb_rr_mux_arb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared defaults and arbitration-mode encodings for the round-robin mux/arbiter slice.
package mux_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_N     = 4;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Grant selection plus rotating priority pointer; the grant is one-hot and purely
// combinational from req and the pointer.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N    = DEFAULT_N,
  parameter int MODE = MODE_RR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] grant_idx;
  logic             found;

  // The fixed-priority search order is simply 0..N-1; round-robin starts at ptr_q.
  always_comb begin : grant_search
    int idx;
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (MODE == MODE_FIXED) ? k : (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (MODE == MODE_RR && advance && found) begin
      ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel valid/ready mux with a single-beat output buffer; one accepted input beat
// per cycle, selected by rr_arbiter.
module rr_mux_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N,
  parameter int MODE  = MODE_RR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [$clog2(N)-1:0] out_sel,
  input  logic                 out_ready
);

  localparam int SEL_W = $clog2(N);

  logic             load_en;
  logic             in_xfer;
  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] mux_data;
  logic [SEL_W-1:0] mux_sel;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;

  // The buffer can take a new beat when empty or when its current beat leaves this cycle.
  assign load_en = !rst && !flush && (!out_valid_q || out_ready);
  assign req     = load_en ? in_valid : '0;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (load_en),
    .grant   (grant)
  );

  assign in_ready = grant;
  assign in_xfer  = |grant;

  always_comb begin
    mux_data = '0;
    mux_sel  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        mux_data = in_data[i*WIDTH +: WIDTH];
        mux_sel  = SEL_W'(i);
      end
    end
  end

  // Flush only drops the valid flag; the last data/sel stay visible.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_sel_d   = mux_sel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: the data register is reset too, because out_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: scoreboard-checked output beats plus direct checks on
// grants, backpressure, flush and a fixed-priority instance.
module tb_rr_mux_arb;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  sel;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  logic [3:0]  in_valid_m1;
  logic [63:0] in_data_m1;
  logic [3:0]  in_ready_m1;
  logic        out_valid_m1;
  logic [15:0] out_data_m1;
  logic [1:0]  out_sel_m1;
  logic        out_ready_m1;

  beat_t sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  rr_mux_arb #(.WIDTH(16), .N(4), .MODE(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  rr_mux_arb #(.WIDTH(16), .N(4), .MODE(1)) dut_fixed (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .in_valid  (in_valid_m1),
    .in_data   (in_data_m1),
    .in_ready  (in_ready_m1),
    .out_valid (out_valid_m1),
    .out_data  (out_data_m1),
    .out_sel   (out_sel_m1),
    .out_ready (out_ready_m1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [15:0] d, input logic [1:0] s);
    beat_t b;
    b.data = d;
    b.sel  = s;
    sb_q.push_back(b);
  endtask

  // Monitor: an output transfer happens at the next edge when these hold mid-cycle.
  initial begin
    beat_t exp_b;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp_b = sb_q.pop_front();
          check("out_data", 32'(out_data), 32'(exp_b.data));
          check("out_sel", 32'(out_sel), 32'(exp_b.sel));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rr_sel  [5];
    logic [15:0] rr_data [5];
    rr_sel  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_data = '{16'h1100, 16'h001A, 16'h8976, 16'hABCD, 16'h1100};

    rst          = 1'b1;
    flush        = 1'b0;
    out_ready    = 1'b1;
    in_valid     = 4'b1111;
    in_data      = {16'hABCD, 16'h8976, 16'h001A, 16'h1100};
    in_valid_m1  = 4'b0000;
    in_data_m1   = '0;
    out_ready_m1 = 1'b1;

    // Reset with every channel requesting.
    repeat (2) begin
      step();
      check("rst_in_ready", 32'(in_ready), 32'h0);
    end
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_sel", 32'(out_sel), 32'h0);
    rst = 1'b0;

    // Round-robin over all four channels, one beat per cycle.
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_grant", 32'(in_ready), 32'(4'b0001 << rr_sel[k]));
      push(rr_data[k], rr_sel[k]);
      step();
    end
    in_valid = 4'b0000;
    step();

    // Backpressure: ch1 beat held while out_ready is low; ptr is now 1.
    in_valid  = 4'b0010;
    in_data   = {16'hABCD, 16'h8976, 16'h5656, 16'h1100};
    out_ready = 1'b0;
    #1;
    check("bp_grant", 32'(in_ready), 32'b0010);
    push(16'h5656, 2'd1);
    step();
    in_data = {16'hABCD, 16'h8976, 16'h7777, 16'h1100};
    repeat (3) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'h0);
      check("bp_out_valid", 32'(out_valid), 32'h1);
      check("bp_out_data", 32'(out_data), 32'h5656);
      check("bp_out_sel", 32'(out_sel), 32'h1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_grant", 32'(in_ready), 32'b0010);
    push(16'h7777, 2'd1);
    step();

    // Bring ptr to 3 via ch2, then wrap-around with ch0 and ch2 valid.
    in_valid = 4'b0100;
    in_data  = {16'hABCD, 16'h2222, 16'h7777, 16'h1100};
    #1;
    check("wrap_prep_grant", 32'(in_ready), 32'b0100);
    push(16'h2222, 2'd2);
    step();
    in_valid = 4'b0101;
    in_data  = {16'hABCD, 16'h0C0C, 16'h7777, 16'h0A0A};
    #1;
    check("wrap_grant_ch0", 32'(in_ready), 32'b0001);
    push(16'h0A0A, 2'd0);
    step();
    #1;
    check("wrap_grant_ch2", 32'(in_ready), 32'b0100);
    push(16'h0C0C, 2'd2);
    step();

    // Load 16'h2345 from ch2 (ptr stays 3), then flush it while ch3 requests.
    in_valid = 4'b0100;
    in_data  = {16'hABCD, 16'h2345, 16'h7777, 16'h0A0A};
    #1;
    check("flush_prep_grant", 32'(in_ready), 32'b0100);
    step();
    check("flush_prep_data", 32'(out_data), 32'h2345);
    flush    = 1'b1;
    in_valid = 4'b1000;
    in_data  = {16'h3333, 16'h2345, 16'h7777, 16'h0A0A};
    #1;
    check("flush_in_ready", 32'(in_ready), 32'h0);
    step();
    check("flush_out_valid", 32'(out_valid), 32'h0);
    check("flush_out_data", 32'(out_data), 32'h2345);
    check("flush_out_sel", 32'(out_sel), 32'h2);
    flush    = 1'b0;
    in_valid = 4'b1111;
    #1;
    check("flush_ptr_kept", 32'(in_ready), 32'b1000);
    push(16'h3333, 2'd3);
    step();
    in_valid = 4'b0000;
    repeat (3) step();
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    // Fixed priority: ch1 always beats ch3.
    in_valid_m1 = 4'b1010;
    in_data_m1  = {16'hDEAD, 16'h0000, 16'hBEEF, 16'h0000};
    for (int k = 0; k < 6; k++) begin
      #1;
      check("fixed_grant", 32'(in_ready_m1), 32'b0010);
      if (k > 0) begin
        check("fixed_out_sel", 32'(out_sel_m1), 32'h1);
        check("fixed_out_data", 32'(out_data_m1), 32'hBEEF);
      end
      step();
    end
    in_valid_m1 = 4'b0000;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
